rs232in: RTL

- 8N1 asynchronous serial receiver.
- Receive-side counterpart of the existing 8N1 transmitter: same bps/frequency parameterisation, same valid/ready byte handshake, with the direction reversed.
- Samples the asynchronous rx pin, centres on each bit, and presents complete bytes on a single-entry holding register.
- Flags framing errors and overruns with single-cycle pulses.

---
 rtl/rs232_pkg.sv | 25 ++
 rtl/rs232_sync.sv | 23 ++
 rtl/rs232in.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the 8N1 serial blocks: receiver state encoding,
// frame geometry, bit-period arithmetic and the 2-of-3 vote helper.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Clocks per bit, rounded to nearest; shared with the transmitter.
  function automatic int calc_period(input int frequency, input int bps);
    return (frequency + bps / 2) / bps;
  endfunction

  // 2-of-3 majority vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle
// (high) line level so a reset never looks like a start bit.
module rs232_sync (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232in.sv
// 8N1 asynchronous serial receiver with a single-entry valid/ready holding
// register, framing-error and overrun pulses.
// Optional build macro RS232IN_MAJORITY_EN: each bit decision becomes a
// 2-of-3 vote of rx_s taken at timer=1, timer=0 and the following cycle.
module rs232in
  import rs232_pkg::*;
#(
  parameter int bps       = 9600,
  parameter int frequency = 50000000,
  parameter int period    = calc_period(frequency, bps),
  parameter int CNT_W     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic [7:0] rx_data,
  output logic       rx_framing_error,
  output logic       rx_overrun
);

  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(period / 2 - 1);
`ifdef RS232IN_MAJORITY_EN
  // The vote adds a hold cycle at timer=0, so reload one shorter to keep
  // consecutive decisions exactly one bit period apart.
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(period - 2);
`else
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(period - 1);
`endif
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             expire;
  logic             sample;

  rs232_sync u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef RS232IN_MAJORITY_EN
  logic vote0;
  logic vote1;
  logic pend;

  // Gather the votes around each bit centre; decide one cycle after timer=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      vote0 <= 1'b1;
      vote1 <= 1'b1;
      pend  <= 1'b0;
    end else if (state == START || state == DATA || state == STOP) begin
      if (pend) begin
        pend <= 1'b0;
      end else if (timer == ZERO) begin
        vote1 <= rx_s;
        pend  <= 1'b1;
      end else begin
        if (timer == ONE) begin
          vote0 <= rx_s;
        end
        pend <= 1'b0;
      end
    end else begin
      pend <= 1'b0;
    end
  end

  assign expire = pend;
  assign sample = majority3(vote0, vote1, rx_s);
`else
  assign expire = (timer == ZERO);
  assign sample = rx_s;
`endif

  // Frame FSM plus the holding register and status pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      timer            <= ZERO;
      bit_idx          <= 3'd0;
      shift            <= 8'h00;
      rx_data_valid    <= 1'b0;
      rx_data          <= 8'h00;
      rx_framing_error <= 1'b0;
      rx_overrun       <= 1'b0;
    end else begin
      rx_framing_error <= 1'b0;
      rx_overrun       <= 1'b0;
      if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            timer <= HALF_M1;
            state <= START;
          end
        end
        START: begin
          if (expire) begin
            if (sample) begin
              state <= IDLE;
            end else begin
              timer   <= RELOAD;
              bit_idx <= 3'd0;
              state   <= DATA;
            end
          end else if (timer != ZERO) begin
            timer <= timer - ONE;
          end
        end
        DATA: begin
          if (expire) begin
            shift <= {sample, shift[7:1]};
            timer <= RELOAD;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else if (timer != ZERO) begin
            timer <= timer - ONE;
          end
        end
        STOP: begin
          if (expire) begin
            if (sample) begin
              // Load if empty or being drained this cycle; else drop it.
              if (!rx_data_valid || rx_data_ready) begin
                rx_data       <= shift;
                rx_data_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              rx_framing_error <= 1'b1;
              state            <= BREAK;
            end
          end else if (timer != ZERO) begin
            timer <= timer - ONE;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
